wb_regfile_slave: RTL and testbench
===================================

// Module: wb_regfile_slave
// PURPOSE
//  Parametrised Wishbone B3 slave register file: NREGS x dw registers, byte-lane writes,
//  programmable wait states, per-register read-only mask, error/retry signalling and
//  hardware-side load ports. It is the generic control/status block behind wb_dsp peripherals.
// PARAMETERS
//  dw          32   data width; multiple of 8; byte lanes SELW = dw/8
//  aw          32   address width
//  NREGS       8    register count; power of 2, >= 2; byte address of reg i = i*SELW
//  WAIT_STATES 0    extra cycles inserted before each classic response (0..15)
//  RO_MASK     0    NREGS-bit mask; bit i set = reg i read-only from the bus
// PORTS
//  wb_clk     in   1          clock
//  wb_rst     in   1          synchronous reset, active high
//  wb_adr_i   in   aw         byte address
//  wb_dat_i   in   dw         write data
//  wb_sel_i   in   SELW       byte-lane enables
//  wb_we_i    in   1          1 = write
//  wb_cyc_i   in   1          bus cycle valid
//  wb_stb_i   in   1          strobe
//  wb_cti_i   in   3          cycle type identifier
//  wb_bte_i   in   2          burst type extension
//  wb_dat_o   out  dw         read data
//  wb_ack_o   out  1          normal termination
//  wb_err_o   out  1          error termination
//  wb_rty_o   out  1          retry termination
//  hw_load_i  in   NREGS      per-register hardware load strobe
//  hw_dat_i   in   NREGS*dw   hardware load data; reg i = [i*dw +: dw]
//  reg_q_o    out  NREGS*dw   all register contents, flattened as above
// BEHAVIOUR
//  - Reset: regs, wb_dat_o = 0; ack/err/rty = 0; FSM = IDLE. Reset mid-transfer aborts it; no write.
//  - FSM: IDLE -> WAIT (WAIT_STATES cycles; skipped when 0) -> RESP (1 cycle) -> IDLE.
//  - IDLE samples cyc&stb. If set at edge ending cycle N, the response (exactly one of
//    ack/err/rty) is high for exactly one cycle: N+1+WAIT_STATES. Next request is sampled
//    no earlier than the cycle after RESP. No double-ack while stb is held.
//  - Address and we/sel/dat are captured at IDLE sampling. cyc low during WAIT -> IDLE, no response, no write.
//  - Decode (priority order):
//    adr[log2(SELW)-1:0] != 0 -> err
//    adr >= NREGS*SELW -> err
//    write to RO_MASK reg -> err
//    write while hw_load_i[idx] is high at commit edge -> rty
//    otherwise -> ack
//    Err/rty: no register change; wb_dat_o holds.
//  - Write commits at the edge ending RESP, byte j updated iff wb_sel_i[j]. sel=0 acks with no change.
//  - Read: wb_dat_o = reg[idx] valid during RESP (sampled at entry to RESP); held until next read ack.
//  - hw_load_i[i] loads hw_dat_i slice every edge, regardless of RO_MASK, with priority over any bus write.
//  - reg_q_o is the registered contents (no bypass); reflects a write the cycle after RESP.
//  - wb_rty_o is only ever asserted by the hw-load collision above.
// CONFIGURATION
//  - WB_REGFILE_BURST_EN defined:
//    - Entry: an acked access with cti=3'b010 and bte=2'b00 enters state BURST.
//    - In BURST, ack is high every cycle that cyc&stb is high, with no wait states.
//    - Address increments by SELW per beat and wraps modulo NREGS*SELW.
//    - Decode/RO/rty rules apply per beat; an err or rty terminates the burst to IDLE.
//    - Exit: cti=3'b111 beat acked -> IDLE; stb low -> hold BURST; cyc low -> IDLE.
//    - cti=3'b010 with bte!=2'b00 -> err.
//  - Not defined: cti/bte ignored; every access is classic.
// TESTING
//  1. Reset, then read all regs -> each returns 0 with ack; err/rty never asserted.
//  2. NREGS=8, WAIT_STATES=2: write 0xDEADBEEF to 0x4 with sel=4'b0101 -> ack 3 cycles
//     after stb; read 0x4 -> 0x00AD00EF; reg_q_o[63:32] matches.
//  3. Error paths:
//     - read 0x20 -> err
//     - write 0x6 -> err
//     - write RO reg 3 (RO_MASK=8'h08) -> err, reg 3 unchanged
//     - hw_load_i[3] with 0x1234 -> reg 3 reads 0x1234
//  4. Write 0x55 to reg 1 with hw_load_i[1]=1, hw data 0xAA, at commit edge -> rty; reg 1 = 0xAA.
//  5. Hold stb high for 10 cycles, WAIT_STATES=0 -> ack toggles 1,0,1,0; exactly one write per ack.
//     Drop cyc during WAIT -> no ack, no write. Assert wb_rst mid-WAIT -> no ack; regs return to 0.
//  6. BURST_EN: 4-beat incrementing write from 0x18 (cti 010,010,010,111) -> 4 consecutive acks;
//     regs 6,7,0,1 written (wrap); FSM back to IDLE. Same with bte=01 -> single err.

Source files
------------

// File: rtl/wb_regfile_slave.sv
// wb_regfile_slave
//   Wishbone B3 slave register file. It holds NREGS registers of dw bits each.
//   It supports byte-lane writes, a programmable number of wait states and a
//   per-register read-only mask. It signals error and retry terminations, and
//   hardware-side load ports can overwrite any register every clock.
//
//   Optional feature: define WB_REGFILE_BURST_EN to enable incrementing bursts
//   (cti=3'b010, bte=2'b00). Without the macro, cti/bte are ignored and every
//   access is a classic single cycle.
//
// Ports
//   wb_clk, wb_rst        clock, synchronous active-high reset
//   wb_adr_i              byte address (reg i lives at i*SELW)
//   wb_dat_i, wb_sel_i    write data and byte-lane enables
//   wb_we_i               1 = write
//   wb_cyc_i, wb_stb_i    bus cycle / strobe
//   wb_cti_i, wb_bte_i    cycle type / burst type (burst build only)
//   wb_dat_o              read data, held until the next acked read
//   wb_ack_o/err_o/rty_o  one-cycle terminations (exactly one per access)
//   hw_load_i, hw_dat_i   per-register hardware load strobe and flattened data
//   reg_q_o               flattened register contents, reg i = [i*dw +: dw]
module wb_regfile_slave #(
  parameter int               dw          = 32,
  parameter int               aw          = 32,
  parameter int               NREGS       = 8,
  parameter int               WAIT_STATES = 0,
  parameter logic [NREGS-1:0] RO_MASK     = '0
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [aw-1:0]       wb_adr_i,
  input  logic [dw-1:0]       wb_dat_i,
  input  logic [dw/8-1:0]     wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [1:0]          wb_bte_i,
  output logic [dw-1:0]       wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  input  logic [NREGS-1:0]    hw_load_i,
  input  logic [NREGS*dw-1:0] hw_dat_i,
  output logic [NREGS*dw-1:0] reg_q_o
);

  localparam int SELW = dw / 8;
  localparam int AB   = $clog2(SELW);
  localparam int IW   = $clog2(NREGS);
  localparam int SPAN = NREGS * SELW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        wcnt;
  logic [dw-1:0]     regs [NREGS];

  logic              req;
  logic [IW-1:0]     in_idx;
  logic              in_err;

  logic [IW-1:0]     idx_p0;
  logic              we_p0;
  logic              err_p0;
  logic [SELW-1:0]   sel_p0;
  logic [dw-1:0]     dat_p0;

  logic              rsp_valid;
  logic              rsp_we;
  logic              rsp_err;
  logic [IW-1:0]     rsp_idx;
  logic [SELW-1:0]   rsp_sel;
  logic [dw-1:0]     rsp_dat;
  logic              rsp_rty;
  logic              bus_ack;
  logic              bus_wr;

  logic              to_resp;
  logic [IW-1:0]     ent_idx;
  logic              ent_we;
  logic              ent_err;

  assign req = wb_cyc_i & wb_stb_i;

  // Decode of the request presented in IDLE. Misalignment and range are
  // checked on the full address, so aliases above the register span error out.
  assign in_idx = wb_adr_i[AB +: IW];

`ifdef WB_REGFILE_BURST_EN
  logic [2:0]    cti_p0;
  logic [1:0]    bte_p0;
  logic [IW-1:0] burst_idx;

  assign in_err = ((wb_adr_i & aw'(SELW - 1)) != '0)
                | (wb_adr_i >= aw'(SPAN))
                | ((wb_cti_i == 3'b010) && (wb_bte_i != 2'b00))
                | (wb_we_i & RO_MASK[in_idx]);
`else
  logic unused_cti_bte;

  assign unused_cti_bte = ^{wb_cti_i, wb_bte_i};
  assign in_err = ((wb_adr_i & aw'(SELW - 1)) != '0)
                | (wb_adr_i >= aw'(SPAN))
                | (wb_we_i & RO_MASK[in_idx]);
`endif

  // State register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= (state == S_WAIT) ? wcnt + 4'd1 : 4'd0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!wb_cyc_i)                           state_nxt = S_IDLE;
        else if (wcnt == 4'(WAIT_STATES - 1))    state_nxt = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
`ifdef WB_REGFILE_BURST_EN
        if (bus_ack && (cti_p0 == 3'b010) && (bte_p0 == 2'b00)) state_nxt = S_BURST;
`endif
      end
      S_BURST: begin
`ifdef WB_REGFILE_BURST_EN
        // stb low with cyc high keeps the burst open; any non-ack or a
        // non-incrementing cti on an acked beat closes it.
        if (!wb_cyc_i)                                state_nxt = S_IDLE;
        else if (rsp_valid && (!bus_ack || (wb_cti_i != 3'b010))) state_nxt = S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: request capture at IDLE sampling
  always_ff @(posedge wb_clk) begin
    if (state == S_IDLE && req) begin
      idx_p0 <= in_idx;
      we_p0  <= wb_we_i;
      err_p0 <= in_err;
      sel_p0 <= wb_sel_i;
      dat_p0 <= wb_dat_i;
`ifdef WB_REGFILE_BURST_EN
      cti_p0 <= wb_cti_i;
      bte_p0 <= wb_bte_i;
`endif
    end
  end

  // Response selection: RESP uses the captured request, BURST uses the live
  // bus with the internally tracked beat address.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_we    = we_p0;
    rsp_err   = err_p0;
    rsp_idx   = idx_p0;
    rsp_sel   = sel_p0;
    rsp_dat   = dat_p0;
    if (state == S_RESP) begin
      rsp_valid = 1'b1;
    end
`ifdef WB_REGFILE_BURST_EN
    else if (state == S_BURST) begin
      rsp_valid = req;
      rsp_we    = wb_we_i;
      rsp_err   = wb_we_i & RO_MASK[burst_idx];
      rsp_idx   = burst_idx;
      rsp_sel   = wb_sel_i;
      rsp_dat   = wb_dat_i;
    end
`endif
  end

  // Retry depends on the hw strobe at the commit edge itself, so it has to be
  // combinational from hw_load_i during the response cycle.
  assign rsp_rty  = rsp_valid & ~rsp_err & rsp_we & hw_load_i[rsp_idx];
  assign bus_ack  = rsp_valid & ~rsp_err & ~rsp_rty;
  assign bus_wr   = bus_ack & rsp_we;

  assign wb_ack_o = bus_ack;
  assign wb_err_o = rsp_valid & rsp_err;
  assign wb_rty_o = rsp_rty;

  // Read data is fetched on the edge that enters RESP; the source request is
  // live in IDLE (zero wait states) or the captured copy out of WAIT.
  assign to_resp = (state_nxt == S_RESP);
  assign ent_idx = (state == S_IDLE) ? in_idx  : idx_p0;
  assign ent_we  = (state == S_IDLE) ? wb_we_i : we_p0;
  assign ent_err = (state == S_IDLE) ? in_err  : err_p0;

`ifdef WB_REGFILE_BURST_EN
  // Beat address advances by one register per acked beat, wrapping naturally
  // in IW bits. Read beats prefetch the next register so data is ready
  // the cycle the next beat is acked.
  always_ff @(posedge wb_clk) begin
    if (bus_ack && state_nxt == S_BURST) burst_idx <= rsp_idx + IW'(1);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst)
      wb_dat_o <= '0;
    else if (to_resp && !ent_we && !ent_err)
      wb_dat_o <= regs[ent_idx];
    else if (bus_ack && !rsp_we && state_nxt == S_BURST)
      wb_dat_o <= regs[rsp_idx + IW'(1)];
  end
`else
  always_ff @(posedge wb_clk) begin
    if (wb_rst)
      wb_dat_o <= '0;
    else if (to_resp && !ent_we && !ent_err)
      wb_dat_o <= regs[ent_idx];
  end
`endif

  // Register array: reset, then hardware load, then bus byte-lane write
  always_ff @(posedge wb_clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (wb_rst) begin
        regs[i] <= '0;
      end else if (hw_load_i[i]) begin
        regs[i] <= hw_dat_i[i*dw +: dw];
      end else if (bus_wr && rsp_idx == IW'(i)) begin
        for (int j = 0; j < SELW; j++) begin
          if (rsp_sel[j]) regs[i][j*8 +: 8] <= rsp_dat[j*8 +: 8];
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_q
      assign reg_q_o[g*dw +: dw] = regs[g];
    end
  endgenerate

endmodule

// File: tb/tb_wb_regfile_slave.sv
module tb_wb_regfile_slave;

  localparam int W = 2;
  localparam logic [7:0] RO = 8'h08;
  localparam logic [2:0] K_ACK = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b001;

  logic         clk;
  logic         rst;

  // main DUT: 2 wait states, reg 3 read-only
  logic [31:0]  adr, dat, dat_o;
  logic [3:0]   sel;
  logic         we, cyc, stb, ack, err, rty;
  logic [2:0]   cti;
  logic [1:0]   bte;
  logic [7:0]   hw_load;
  logic [255:0] hw_dat, reg_q;

  // second DUT: zero wait states, held-strobe behaviour
  logic [31:0]  b_adr, b_dat, b_dat_o;
  logic [3:0]   b_sel;
  logic         b_we, b_cyc, b_stb, b_ack, b_err, b_rty;
  logic [2:0]   b_cti;
  logic [1:0]   b_bte;
  logic [7:0]   b_hw_load;
  logic [255:0] b_hw_dat, b_reg_q;

  // model and expectations
  logic [31:0]  m_regs [8];
  logic [31:0]  m_dato;
  logic [2:0]   exp_resp [int];
  int           cyc_n = 0;
  bit           chk_en;
  bit           pin_on;
  int           pin_idx;
  logic [31:0]  pin_val;
  bit           b_on;
  bit           b_exp_ack;
  logic [31:0]  b_exp_reg;
  int           errors = 0;
  int           checks = 0;

  wb_regfile_slave #(.dw(32), .aw(32), .NREGS(8), .WAIT_STATES(W), .RO_MASK(RO)) dut (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .hw_load_i(hw_load), .hw_dat_i(hw_dat), .reg_q_o(reg_q));

  wb_regfile_slave #(.dw(32), .aw(32), .NREGS(8), .WAIT_STATES(0), .RO_MASK(8'h00)) dut_b (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel),
    .wb_we_i(b_we), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_cti_i(b_cti), .wb_bte_i(b_bte),
    .wb_dat_o(b_dat_o), .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_rty_o(b_rty),
    .hw_load_i(b_hw_load), .hw_dat_i(b_hw_dat), .reg_q_o(b_reg_q));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // Compare process: every cycle, terminations, read data and register image
  always @(negedge clk) begin
    if (chk_en) begin
      logic [255:0] flat;
      logic [2:0]   er;
      for (int i = 0; i < 8; i++) flat[i*32 +: 32] = m_regs[i];
      er = exp_resp.exists(cyc_n) ? exp_resp[cyc_n] : 3'b000;
      check("ack_err_rty", {ack, err, rty}, er);
      check("dat_o", dat_o, m_dato);
      check("reg_q", reg_q, flat);
      if (pin_on) begin
        if (pin_idx < 0) check("pin_dat_o", dat_o, pin_val);
        else             check("pin_reg", reg_q[pin_idx*32 +: 32], pin_val);
      end
      if (b_on) begin
        check("b_ack_err_rty", {b_ack, b_err, b_rty}, {b_exp_ack, 2'b00});
        check("b_reg2", b_reg_q[95:64], b_exp_reg);
      end
    end
  end

  // Termination the rules require for a single classic access
  function automatic logic [2:0] model_kind(input logic [31:0] a, input bit w, input bit col,
                                            input logic [2:0] ct, input logic [1:0] bt);
    bit bad_burst;
    bad_burst = 1'b0;
`ifdef WB_REGFILE_BURST_EN
    bad_burst = (ct == 3'b010) && (bt != 2'b00);
`else
    if (ct == 3'b111 && bt == 2'b11) bad_burst = 1'b0;
`endif
    if (a % 4 != 0)             return K_ERR;
    if (a >= 32)                return K_ERR;
    if (bad_burst)              return K_ERR;
    if (w && RO[a / 4])         return K_ERR;
    if (w && col)               return K_RTY;
    return K_ACK;
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic classic(input logic [31:0] a, input bit w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] ct, input logic [1:0] bt,
                         input bit col, input logic [31:0] cd);
    logic [2:0] k;
    int idx;
    idx = (a / 4) % 8;
    k = model_kind(a, w, col, ct, bt);
    adr = a; we = w; dat = d; sel = s; cti = ct; bte = bt; cyc = 1'b1; stb = 1'b1;
    exp_resp[cyc_n + 1 + W] = k;
    repeat (1 + W) @(posedge clk);
    #1;
    if (k == K_ACK && !w) m_dato = m_regs[idx];
    if (col) begin
      hw_load[idx] = 1'b1;
      hw_dat[idx*32 +: 32] = cd;
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    if (col) begin
      m_regs[idx] = cd;
      hw_load = '0;
    end else if (k == K_ACK && w) begin
      for (int j = 0; j < 4; j++) if (s[j]) m_regs[idx][j*8 +: 8] = d[j*8 +: 8];
    end
  endtask

  task automatic hw_ld(input int idx, input logic [31:0] v);
    hw_load[idx] = 1'b1;
    hw_dat[idx*32 +: 32] = v;
    @(posedge clk);
    #1;
    hw_load = '0;
    m_regs[idx] = v;
  endtask

  task automatic pin(input int idx, input logic [31:0] v);
    pin_idx = idx; pin_val = v; pin_on = 1'b1;
    @(negedge clk);
    #1;
    pin_on = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef WB_REGFILE_BURST_EN
  logic [31:0] bd [4];
`endif

  initial begin
    rst = 1'b1; chk_en = 1'b0; pin_on = 1'b0; pin_idx = -1; pin_val = '0;
    adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    hw_load = '0; hw_dat = '0;
    b_adr = '0; b_dat = '0; b_sel = '0; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
    b_cti = '0; b_bte = '0; b_hw_load = '0; b_hw_dat = '0;
    b_on = 1'b0; b_exp_ack = 1'b0; b_exp_reg = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_dato = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // reset state: every register reads back zero with ack
    for (int i = 0; i < 8; i++) classic(32'(i * 4), 1'b0, '0, 4'hF, 3'b000, 2'b00, 1'b0, '0);

    // byte-lane write then read back
    classic(32'h4, 1'b1, 32'hDEADBEEF, 4'b0101, 3'b000, 2'b00, 1'b0, '0);
    classic(32'h4, 1'b0, '0, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    pin(-1, 32'h00AD00EF);
    pin(1, 32'h00AD00EF);

    // error paths and hardware load
    classic(32'h20, 1'b0, '0, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    classic(32'h6, 1'b1, 32'h11111111, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    classic(32'hC, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    pin(3, 32'h0);
    hw_ld(3, 32'h1234);
    classic(32'hC, 1'b0, '0, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    pin(-1, 32'h1234);

    // hw load collides with bus write at commit edge
    classic(32'h4, 1'b1, 32'h55, 4'hF, 3'b000, 2'b00, 1'b1, 32'hAA);
    pin(1, 32'hAA);

    // sel=0 write acks without changing anything
    classic(32'h10, 1'b1, 32'hCAFEF00D, 4'b0000, 3'b000, 2'b00, 1'b0, '0);

    // zero-wait DUT: strobe held for 10 cycles, data changes every cycle
    for (int t = 0; t <= 10; t++) begin
      b_cyc = (t < 10); b_stb = (t < 10); b_we = 1'b1; b_adr = 32'h8; b_sel = 4'hF;
      b_dat = 32'h100 + 32'(t);
      b_exp_ack = (t % 2 == 1);
      if (t < 2)            b_exp_reg = 32'h0;
      else if (t % 2 == 0)  b_exp_reg = 32'h100 + 32'(t - 2);
      else                  b_exp_reg = 32'h100 + 32'(t - 3);
      b_on = 1'b1;
      @(posedge clk); #1;
    end
    b_on = 1'b0; b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;

    // cyc dropped during WAIT: no response, no write
    adr = 32'h14; we = 1'b1; dat = 32'h77; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    pin(5, 32'h0);

    // reset asserted mid-WAIT: no response, all registers cleared
    classic(32'h8, 1'b1, 32'h99, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    pin(2, 32'h99);
    adr = 32'h8; we = 1'b1; dat = 32'h5A5A; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_dato = '0;
    pin(2, 32'h0);
    pin(-1, 32'h0);
    pin(1, 32'h0);

`ifdef WB_REGFILE_BURST_EN
    // 4-beat incrementing write from 0x18, wrapping to regs 0 and 1
    bd[0] = 32'hA6A60006; bd[1] = 32'hB7B70007; bd[2] = 32'hC0C00000; bd[3] = 32'hD1D10001;
    adr = 32'h18; we = 1'b1; sel = 4'hF; dat = bd[0]; cti = 3'b010; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    for (int b = 0; b < 4; b++) exp_resp[cyc_n + 1 + W + b] = K_ACK;
    repeat (1 + W) @(posedge clk);
    #1;
    for (int b = 1; b <= 4; b++) begin
      @(posedge clk); #1;
      m_regs[(6 + b - 1) % 8] = bd[b - 1];
      if (b < 4) begin
        adr = 32'(((6 + b) % 8) * 4);
        dat = bd[b];
        cti = (b == 3) ? 3'b111 : 3'b010;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    pin(0, 32'hC0C00000);
    pin(7, 32'hB7B70007);
    classic(32'h18, 1'b0, '0, 4'hF, 3'b000, 2'b00, 1'b0, '0);
    pin(-1, 32'hA6A60006);
    // unsupported burst type terminates with a single error
    classic(32'h0, 1'b1, 32'h5, 4'hF, 3'b010, 2'b01, 1'b0, '0);
    pin(0, 32'hC0C00000);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
